frame_timer_bank: RTL and testbench
===================================

Name: frame_timer_bank

Overview:
Parametrised multi-channel successor to the single frame counter that drives seven-segment animation timing. Holds NUM_CH independent down-counters of CNT_W bits, fed by a shared programmable prescaler. Each channel has one-shot or auto-reload mode, start/stop control, a reload register loaded byte-wise from the 8-bit datapath, and a sticky expiry flag. Sits beside the dcache/control logic; the processor loads reload values and polls active/expired bits as source registers.

Parameters:
NUM_CH, 4, number of timer channels (>=1)
CNT_W, 32, counter and reload width; must be a multiple of 8
PRESC_W, 8, prescaler width
CH_W, derived CLOG2(NUM_CH) (min 1), channel-select width
BYTE_W, derived CLOG2(CNT_W/8) (min 1), byte-select width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cfg_wen_in  in  1  write one reload byte this cycle
cfg_ch_in  in  CH_W  channel addressed by the write
cfg_byte_in  in  BYTE_W  byte lane (0 = LSB)
cfg_data_in  in  8  byte value
mode_in  in  NUM_CH  per channel: 1 = auto-reload, 0 = one-shot (sampled at each expiry)
start_in  in  NUM_CH  per-channel pulse: load counter from reload and run
stop_in  in  NUM_CH  per-channel pulse: halt, counter holds its value
ack_in  in  NUM_CH  per-channel clear of the expired flag
presc_in  in  PRESC_W  tick period minus one
tick_out  out  1  registered prescaler tick
active_out  out  NUM_CH  channel running (registered)
expired_out  out  NUM_CH  sticky expiry flag (registered)

Behaviour:
- Reset (rst_n low, async): prescaler count, every counter, every reload register, tick_out, active_out and expired_out all go to 0. Deassertion is synchronous to clk by the integrator; no internal synchroniser.
- Prescaler: pcnt increments each cycle. When pcnt == presc_in, next pcnt = 0 and tick_out = 1 for one cycle (registered, so it appears the cycle after the match). presc_in = 0 gives tick_out = 1 every cycle. If presc_in is lowered below pcnt, pcnt wraps at 2^PRESC_W. The prescaler free-runs and is not aligned to start.
- Reload write: when cfg_wen_in is high, reload[cfg_ch_in][8*cfg_byte_in +: 8] is written next edge. cfg_ch_in >= NUM_CH is ignored. A write never disturbs a running count; it takes effect at the next start or auto-reload.
- Channel FSM, states IDLE/RUN; active_out = (state == RUN). Per-cycle priority is stop > start > tick.
  - stop: go to IDLE and hold the counter.
  - start: counter <= reload, go to RUN. If reload == 0, stay IDLE with counter 0 and set expired next edge.
  - RUN on tick with counter > 1: counter <= counter - 1.
  - RUN on tick with counter == 1: set expired. If mode_in = 1, counter <= reload and stay in RUN (if reload == 0, go to IDLE). If mode_in = 0, counter <= 0 and go to IDLE.
  - Without a tick, the counter holds.
- Latency: with presc_in = 0, start at edge N makes active_out = 1 after edge N. Reload R sets expired_out = 1 after edge N+R, and active_out falls on the same edge (one-shot).
- Expired flag: a set and an ack in the same cycle leave the flag set. An ack alone clears it next edge.
- Start while RUN restarts from reload with no expiry. Stop while IDLE has no effect.

Decomposition:
- Shared defs package: CLOG2 macro (existing), MODE_ONESHOT/MODE_RELOAD constants, FT_IDLE/FT_RUN state encodings.
- Sub-module frame_timer_ch: one channel (reload register, counter, FSM, expired flag), instantiated NUM_CH times with a generate loop.
- The prescaler and write-address decode live in the top.

Test Plan:
- Reset: assert rst_n = 0 mid-count with ch0 running -> all outputs 0 immediately, asynchronously; after release, ch0 stays IDLE.
- One-shot: presc_in = 0, write ch0 reload = 5 (byte 0), pulse start[0] -> active_out[0] high for exactly 5 cycles, expired_out[0] rises as it falls, counter reads 0.
- Auto-reload with prescaler: presc_in = 3, ch1 reload = 2, mode[1] = 1 -> tick_out every 4 cycles; expiry every 8 cycles; ack[1] clears the flag; an ack coinciding with an expiry leaves it set.
- Byte-wise 32-bit load: write ch2 bytes 0..3 = 0x01,0x00,0x01,0x00 (0x00010001) then start -> no expiry before 65537 ticks; a write during the run does not change the current count.
- Priority/edge cases: start and stop pulsed together -> IDLE. Start with reload 0 -> expired next cycle, active stays 0. Write with cfg_ch_in = NUM_CH -> no channel changes.
- Independence: all 4 channels started with reloads 1, 2, 3, 4 at presc_in = 0 -> expiries land on consecutive cycles, and each channel's flags are unaffected by the others.

Source files
------------

// File: rtl/frame_timer_bank_pkg.sv
// Shared definitions for the frame timer bank.
// Holds mode and state encodings plus a ceil-log2 helper.
package frame_timer_bank_pkg;

  localparam logic [0:0] MODE_ONESHOT = 1'b0;
  localparam logic [0:0] MODE_RELOAD  = 1'b1;

  localparam logic [0:0] FT_IDLE = 1'b0;
  localparam logic [0:0] FT_RUN  = 1'b1;

  // ceil(log2(n)), never below 1 so select fields stay legal
  function automatic int ft_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/frame_timer_bank_if.sv
// Config/control/status bundle of the frame timer bank.
// master drives cfg/mode/start/stop/ack/presc; slave returns tick/active/expired.
interface frame_timer_bank_if #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 8
) ();

  localparam int CH_W   = frame_timer_bank_pkg::ft_clog2(NUM_CH);
  localparam int BYTE_W = frame_timer_bank_pkg::ft_clog2(CNT_W / 8);

  logic              cfg_wen_in;
  logic [CH_W-1:0]   cfg_ch_in;
  logic [BYTE_W-1:0] cfg_byte_in;
  logic [7:0]        cfg_data_in;
  logic [NUM_CH-1:0] mode_in;
  logic [NUM_CH-1:0] start_in;
  logic [NUM_CH-1:0] stop_in;
  logic [NUM_CH-1:0] ack_in;
  logic [PRESC_W-1:0] presc_in;
  logic              tick_out;
  logic [NUM_CH-1:0] active_out;
  logic [NUM_CH-1:0] expired_out;

  modport master (
    output cfg_wen_in, cfg_ch_in, cfg_byte_in, cfg_data_in,
    output mode_in, start_in, stop_in, ack_in, presc_in,
    input  tick_out, active_out, expired_out
  );

  modport slave (
    input  cfg_wen_in, cfg_ch_in, cfg_byte_in, cfg_data_in,
    input  mode_in, start_in, stop_in, ack_in, presc_in,
    output tick_out, active_out, expired_out
  );

endinterface

// File: rtl/frame_timer_bank_ch.sv
// One timer channel: byte-loaded reload register, down-counter, IDLE/RUN FSM, sticky expiry.
// Ports: clk, rst_n, wen/byte/data write, mode/start/stop/ack/tick controls, active/expired status.
module frame_timer_ch
  import frame_timer_bank_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int BYTE_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wen_in,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic [7:0]        data_in,
  input  logic              mode_in,
  input  logic              start_in,
  input  logic              stop_in,
  input  logic              ack_in,
  input  logic              tick_in,
  output logic              active_out,
  output logic              expired_out
);

  localparam int NB = CNT_W / 8;

  logic [CNT_W-1:0] reload_q, reload_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [0:0]       state_q, state_d;
  logic             expired_q, expired_d;
  logic             fire;

  always_comb begin
    reload_d = reload_q;
    for (int b = 0; b < NB; b++) begin
      if (wen_in && byte_in == BYTE_W'(b)) begin
        reload_d[8*b +: 8] = data_in;
      end
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    fire    = 1'b0;
    if (stop_in) begin
      state_d = FT_IDLE;
    end else if (start_in) begin
      if (reload_q == '0) begin
        cnt_d   = '0;
        state_d = FT_IDLE;
        fire    = 1'b1;
      end else begin
        cnt_d   = reload_q;
        state_d = FT_RUN;
      end
    end else if (state_q == FT_RUN && tick_in) begin
      if (cnt_q > CNT_W'(1)) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        fire = 1'b1;
        // a zero reload cannot rearm, so auto-reload falls back to IDLE
        if (mode_in == MODE_RELOAD && reload_q != '0) begin
          cnt_d = reload_q;
        end else begin
          cnt_d   = '0;
          state_d = FT_IDLE;
        end
      end
    end
    // a new expiry outranks a same-cycle ack
    expired_d = fire | (expired_q & ~ack_in);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reload_q  <= '0;
      cnt_q     <= '0;
      state_q   <= FT_IDLE;
      expired_q <= 1'b0;
    end else begin
      reload_q  <= reload_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      expired_q <= expired_d;
    end
  end

  assign active_out  = (state_q == FT_RUN);
  assign expired_out = expired_q;

endmodule

// File: rtl/frame_timer_bank.sv
// Bank of NUM_CH frame timers sharing one free-running prescaler.
// Ports: clk, rst_n, bus (cfg write, mode/start/stop/ack/presc in; tick/active/expired out).
module frame_timer_bank
  import frame_timer_bank_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  frame_timer_bank_if.slave  bus
);

  localparam int CH_W   = ft_clog2(NUM_CH);
  localparam int BYTE_W = ft_clog2(CNT_W / 8);

  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic               tick_q, tick_d;
  logic [NUM_CH-1:0]  active_w;
  logic [NUM_CH-1:0]  expired_w;

  // lowering presc below pcnt lets pcnt run on and wrap naturally
  always_comb begin
    tick_d = (pcnt_q == bus.presc_in);
    pcnt_d = tick_d ? '0 : pcnt_q + PRESC_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q <= '0;
      tick_q <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      tick_q <= tick_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wen;
    // unused channel codes match no instance and are dropped
    assign wen = bus.cfg_wen_in && (bus.cfg_ch_in == CH_W'(i));

    frame_timer_ch #(
      .CNT_W  (CNT_W),
      .BYTE_W (BYTE_W)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .wen_in      (wen),
      .byte_in     (bus.cfg_byte_in),
      .data_in     (bus.cfg_data_in),
      .mode_in     (bus.mode_in[i]),
      .start_in    (bus.start_in[i]),
      .stop_in     (bus.stop_in[i]),
      .ack_in      (bus.ack_in[i]),
      .tick_in     (tick_q),
      .active_out  (active_w[i]),
      .expired_out (expired_w[i])
    );
  end

  assign bus.tick_out    = tick_q;
  assign bus.active_out  = active_w;
  assign bus.expired_out = expired_w;

endmodule

// File: tb/tb_frame_timer_bank.sv
// Self-checking bench for frame_timer_bank.
// Directed steps plus a random phase, checked against an arithmetic reference model.
module tb_frame_timer_bank;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  frame_timer_bank_if #(.NUM_CH(4), .CNT_W(32), .PRESC_W(8)) bus ();
  frame_timer_bank_if #(.NUM_CH(3), .CNT_W(8), .PRESC_W(8)) bus3 ();

  frame_timer_bank #(.NUM_CH(4), .CNT_W(32), .PRESC_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  frame_timer_bank #(.NUM_CH(3), .CNT_W(8), .PRESC_W(8)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  int total = 0;
  int bad = 0;

  longint unsigned rel [4];
  longint unsigned left [4];
  bit run [4];
  bit expf [4];
  int pc;
  bit tk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    for (int i = 0; i < 4; i++) begin
      rel[i] = 0; left[i] = 0; run[i] = 0; expf[i] = 0;
    end
    pc = 0;
    tk = 0;
  endtask

  // advance the model by one cycle, clock the DUT, compare outputs
  task automatic step();
    logic [3:0] av, ev;
    int b, c, p;
    bit ntk;
    for (int i = 0; i < 4; i++) begin
      bit fire;
      fire = 0;
      if (bus.stop_in[i]) begin
        run[i] = 0;
      end else if (bus.start_in[i]) begin
        if (rel[i] == 0) begin
          left[i] = 0; run[i] = 0; fire = 1;
        end else begin
          left[i] = rel[i]; run[i] = 1;
        end
      end else if (run[i] && tk) begin
        left[i] = left[i] - 1;
        if (left[i] == 0) begin
          fire = 1;
          if (bus.mode_in[i] && rel[i] != 0) left[i] = rel[i];
          else run[i] = 0;
        end
      end
      expf[i] = fire | (expf[i] & !bus.ack_in[i]);
    end
    if (bus.cfg_wen_in) begin
      b = int'(bus.cfg_byte_in);
      c = int'(bus.cfg_ch_in);
      rel[c] = (rel[c] & ~(64'hFF << (8 * b)))
             | (64'(bus.cfg_data_in) << (8 * b));
    end
    p = int'(bus.presc_in);
    ntk = (pc == p);
    pc = ntk ? 0 : (pc + 1) % 256;
    tk = ntk;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      av[i] = run[i];
      ev[i] = expf[i];
    end
    chk("tick", bus.tick_out, tk);
    chk("active", bus.active_out, av);
    chk("expired", bus.expired_out, ev);
    bus.start_in = '0;
    bus.stop_in = '0;
    bus.ack_in = '0;
    bus.cfg_wen_in = 1'b0;
  endtask

  task automatic wr(input int ch, input int bt, input int data);
    bus.cfg_wen_in = 1'b1;
    bus.cfg_ch_in = 2'(ch);
    bus.cfg_byte_in = 2'(bt);
    bus.cfg_data_in = 8'(data);
    step();
  endtask

  initial begin
    bus.cfg_wen_in = 0; bus.cfg_ch_in = 0; bus.cfg_byte_in = 0;
    bus.cfg_data_in = 0; bus.mode_in = 0; bus.start_in = 0;
    bus.stop_in = 0; bus.ack_in = 0; bus.presc_in = 0;
    bus3.cfg_wen_in = 0; bus3.cfg_ch_in = 0; bus3.cfg_byte_in = 0;
    bus3.cfg_data_in = 0; bus3.mode_in = 0; bus3.start_in = 0;
    bus3.stop_in = 0; bus3.ack_in = 0; bus3.presc_in = 0;
    mreset();
    #2;
    chk("rst_tick", bus.tick_out, 0);
    chk("rst_active", bus.active_out, 0);
    chk("rst_expired", bus.expired_out, 0);
    #10 rst_n = 1'b1;

    // one-shot, reload 5
    step();
    wr(0, 0, 5);
    bus.start_in[0] = 1'b1;
    step();
    chk("os_act_rise", bus.active_out[0], 1);
    repeat (4) step();
    chk("os_act_hold", bus.active_out[0], 1);
    chk("os_no_exp", bus.expired_out[0], 0);
    step();
    chk("os_act_fall", bus.active_out[0], 0);
    chk("os_exp_rise", bus.expired_out[0], 1);
    bus.ack_in[0] = 1'b1;
    step();
    chk("os_ack", bus.expired_out[0], 0);

    // asynchronous reset mid-count
    wr(0, 0, 50);
    bus.start_in[0] = 1'b1;
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_active", bus.active_out, 0);
    chk("arst_expired", bus.expired_out, 0);
    chk("arst_tick", bus.tick_out, 0);
    mreset();
    #3 rst_n = 1'b1;
    repeat (5) step();
    chk("arst_idle", bus.active_out[0], 0);

    // auto-reload behind a prescaler
    bus.presc_in = 8'd3;
    wr(1, 0, 2);
    bus.mode_in[1] = 1'b1;
    bus.start_in[1] = 1'b1;
    step();
    repeat (40) step();
    bus.ack_in[1] = 1'b1;
    step();
    for (int w = 0; w < 20 && !(run[1] && tk && left[1] == 1); w++) step();
    if (!(run[1] && tk && left[1] == 1)) chk("ack_wait", 0, 1);
    bus.ack_in[1] = 1'b1;
    step();
    chk("ack_coincide", bus.expired_out[1], 1);
    bus.ack_in[1] = 1'b1;
    step();
    chk("ack_alone", bus.expired_out[1], 0);
    bus.stop_in[1] = 1'b1;
    step();
    bus.mode_in[1] = 1'b0;

    // byte-wise 32-bit load
    bus.presc_in = 8'd0;
    wr(2, 0, 1); wr(2, 1, 0); wr(2, 2, 1); wr(2, 3, 0);
    bus.start_in[2] = 1'b1;
    step();
    repeat (500) step();
    wr(2, 2, 0);
    repeat (500) step();
    chk("long_running", bus.active_out[2], 1);
    chk("long_no_exp", bus.expired_out[2], 0);
    bus.stop_in[2] = 1'b1;
    step();
    wr(2, 0, 2); wr(2, 1, 1);
    bus.start_in[2] = 1'b1;
    step();
    repeat (257) step();
    chk("b258_early", bus.expired_out[2], 0);
    step();
    chk("b258_exp", bus.expired_out[2], 1);
    bus.ack_in[2] = 1'b1;
    step();

    // start+stop together, start with zero reload
    wr(3, 0, 9);
    bus.start_in[3] = 1'b1;
    bus.stop_in[3] = 1'b1;
    step();
    chk("ss_active", bus.active_out[3], 0);
    chk("ss_expired", bus.expired_out[3], 0);
    bus.start_in[0] = 1'b1;
    step();
    chk("z_expired", bus.expired_out[0], 1);
    chk("z_active", bus.active_out[0], 0);
    bus.ack_in[0] = 1'b1;
    step();

    // independence: reloads 1..4 expire on consecutive cycles
    wr(0, 0, 1); wr(1, 0, 2); wr(2, 0, 3); wr(2, 1, 0); wr(3, 0, 4);
    bus.start_in = 4'hF;
    step();
    chk("ind_start", bus.expired_out, 0);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("ind_exp", bus.expired_out, (1 << k) - 1);
      chk("ind_act", bus.active_out, 4'hF & ~((1 << k) - 1));
    end
    bus.ack_in = 4'hF;
    step();

    // random phase
    bus.presc_in = 8'($urandom_range(0, 3));
    for (int n = 0; n < 600; n++) begin
      if (n % 50 == 0) bus.mode_in = 4'($urandom);
      for (int i = 0; i < 4; i++) begin
        bus.start_in[i] = ($urandom_range(0, 7) == 0);
        bus.stop_in[i] = ($urandom_range(0, 15) == 0);
        bus.ack_in[i] = ($urandom_range(0, 3) == 0);
      end
      if ($urandom_range(0, 3) == 0) begin
        bus.cfg_wen_in = 1'b1;
        bus.cfg_ch_in = 2'($urandom_range(0, 3));
        bus.cfg_byte_in = 2'd0;
        bus.cfg_data_in = 8'($urandom_range(0, 7));
      end
      step();
    end

    // 3-channel 8-bit bank: out-of-range channel and lane writes dropped
    bus3.cfg_wen_in = 1'b1;
    bus3.cfg_ch_in = 2'd3;
    bus3.cfg_byte_in = 1'b0;
    bus3.cfg_data_in = 8'd7;
    step();
    bus3.cfg_ch_in = 2'd0;
    bus3.cfg_byte_in = 1'b1;
    bus3.cfg_data_in = 8'd9;
    step();
    bus3.cfg_wen_in = 1'b0;
    bus3.start_in = 3'b111;
    step();
    bus3.start_in = 3'b000;
    chk("nc_expired", bus3.expired_out, 3'b111);
    chk("nc_active", bus3.active_out, 3'b000);
    bus3.ack_in = 3'b111;
    step();
    bus3.ack_in = 3'b000;
    chk("nc_ack", bus3.expired_out, 3'b000);
    bus3.cfg_wen_in = 1'b1;
    bus3.cfg_ch_in = 2'd1;
    bus3.cfg_byte_in = 1'b0;
    bus3.cfg_data_in = 8'd2;
    step();
    bus3.cfg_wen_in = 1'b0;
    bus3.start_in = 3'b010;
    step();
    bus3.start_in = 3'b000;
    chk("nc_run", bus3.active_out, 3'b010);
    step();
    chk("nc_run_exp0", bus3.expired_out, 3'b000);
    step();
    chk("nc_done_exp", bus3.expired_out, 3'b010);
    chk("nc_done_act", bus3.active_out, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
